vectored_interrupt_controller: RTL and testbench
================================================

# vectored_interrupt_controller

Parametrised, multi-source successor to the single-vector interrupt controller. It sits beside the PC mux and the IF/ID register. It latches rising edges on `NUM_SRC` interrupt lines into a pending register and applies a software-writable mask. It picks the highest-priority pending source, sequences the pipeline flush/stall into and out of the ISR, saves the return PC, and supplies a per-source ISR entry vector to instruction memory.

## Interface
Parameters:
- `NUM_SRC`, 4: number of interrupt sources, 1..16.
- `PC_W`, 12: PC address width, equal to `PC_ADDR_BITS`.
- `START_CYC`, 5: start-sequence length in cycles, 2..7.
- `END_CYC`, 3: end-sequence length in cycles, 2..7.
- `VEC_BASE`, 0: ISR memory address of source 0's entry.
- `VEC_STRIDE`, 16: address spacing between per-source entries.

Ports:
- Clock and reset (already decided): clock `clk`; reset `nrst`, synchronous, active-low.
- `clk`, input, 1: ungated clock.
- `nrst`, input, 1: reset.
- `stall`, input, 1: external stall from `sf_controller`.
- `if_pcnew`, input, PC_W: next-PC value.
- `if_PC`, input, PC_W: current PC.
- `exe_opcode`, input, 7: EXE-stage opcode; `OPC_URET` ends the ISR.
- `int_sig`, input, NUM_SRC: level interrupt lines.
- `mask_we`, input, 1: mask write strobe.
- `mask_wdata`, input, NUM_SRC: new mask; bit=1 enables the source.
- `if_prediction`, `id_jump_in_bht`, `id_sel_pc`, input, 1 each: BHT status.
- `exe_correction`, input, 2: BHT status.
- `ISR_PC_flush`, output, 1: flush PC.
- `ISR_pipe_flush`, output, 1: flush IF/ID.
- `sel_ISR`, output, 1: fetch from ISR memory.
- `ret_ISR`, output, 1: select `save_PC` into PC.
- `ISR_running`, output, 1: ISR body executing.
- `save_PC`, output, PC_W: return address.
- `isr_vector`, output, PC_W: ISR entry address.
- `active_id`, output, $clog2(NUM_SRC) (min 1): source being serviced.
- `pending`, output, NUM_SRC: pending register.
- `mask`, output, NUM_SRC: mask register.

## Operation
- **Reset values:** all outputs 0, except `mask`, which resets to all ones. FSM resets to IDLE and the counter to 0. The edge-detect history register resets to 0.
- **Pending:**
  - Set: `pending[i]` sets on the rising edge of `int_sig[i]`, i.e. `int_sig[i]` high while `hist[i]` is 0.
  - Clear: the bit clears on acceptance of source i.
  - Same-cycle set and clear: set wins.
  - Masking: masked sources still pend but are not accepted.
- **Priority:** lowest index wins among `pending & mask`.
- **FSM states:**
  - IDLE: if `pending & mask` ≠ 0, accept the winner. Latch `active_id`, clear its pending bit, set `cnt`=1, go to START.
  - START: `cnt` increments each cycle `stall`=0. At `cnt`==START_CYC go to RUN; `sel_ISR`=1 and `ISR_running`=1 from the next cycle.
  - RUN: `exe_opcode`==`OPC_URET` → END with `cnt`=1. Same edge: `ret_ISR`=1, `sel_ISR`=0.
  - END: `cnt` increments when `stall`=0. At `cnt`==END_CYC go to IDLE and clear `ISR_running` and `ret_ISR`.
- **Flush outputs:** both are gated by `stall`=0, with `seq` = (state ∈ {START, END}) or (`exe_opcode`==`OPC_URET`).
  - `ISR_PC_flush` = `seq` & !`ret_ISR` & (`cnt`≥2 | `save_PC`==`if_PC`).
  - `ISR_pipe_flush` = `seq` & ((`cnt`≥2 & !`ret_ISR`) | `ret_ISR` | `save_PC`==`if_PC`).
- **save_PC:** loads `if_pcnew` on the acceptance cycle+1, and on any START-state cycle with `exe_correction`≠0, `if_prediction`, or (`id_sel_pc` & !`id_jump_in_bht`). It never loads in RUN or END.
- **Arithmetic:** `isr_vector` = VEC_BASE + `active_id`*VEC_STRIDE, truncated to PC_W (modulo 2^PC_W).
- **Mask write:** takes effect the next cycle. It does not affect a source that has already been accepted.
- **URET outside RUN:** ignored.
- **Nesting:** none. Edges arriving in START, RUN or END pend and are serviced from IDLE on the cycle after END completes.

## Timing
- **Edge to START:** 2 cycles, without stall (edge latch, then accept).
- **START length:** START_CYC non-stalled cycles, followed by the first ISR fetch.
- **URET to main fetch:** END_CYC non-stalled cycles.
- **Stall:** freezes `cnt`, the FSM and the flush outputs. Pending and edge capture continue.
- **Reset:** an `nrst` low mid-sequence returns every register to its reset value on the same edge.

## Configuration
- `INTC_VECTORED_EN` defined: `isr_vector` is per-source as specified under Operation.
- Undefined: `isr_vector` = VEC_BASE for all sources. `active_id` is still driven so the ISR can poll the active source.

## Test plan
- **Single source:** NUM_SRC=4. Pulse `int_sig[2]` at PC 0x040 → `active_id`=2, `isr_vector`=0x020, `sel_ISR` rises 2+5 cycles later, `save_PC`=0x041 (`if_pcnew`). URET → `ret_ISR` for 3 cycles, `ISR_running`=0 after.
- **Priority:** rise `int_sig[3]` and `int_sig[1]` on the same cycle → serves 1; `pending`=4'b1000; after END, serves 3.
- **Mask:** `mask`=4'b1110 with `int_sig[0]` edge → `pending[0]`=1, no START. Write `mask`=4'b1111 → accepted next cycle.
- **Branch in START:** `exe_correction`=2'b01 at `cnt`=3 with `if_pcnew`=0x080 → `save_PC`=0x080.
- **Stall:** hold `stall` for 4 cycles at `cnt`=2 → `cnt` stays 2, both flushes 0; START completes 4 cycles late.
- **Mid-sequence reset:** `nrst`=0 during RUN → all outputs 0, `mask`=all ones.

Source files
------------

// File: rtl/vectored_interrupt_controller.sv
// Multi-source vectored interrupt controller: edge capture, mask, priority, ISR sequencing.
// Optional INTC_VECTORED_EN gives per-source isr_vector; otherwise every source enters at VEC_BASE.
module vectored_interrupt_controller #(
  parameter int NUM_SRC    = 4,
  parameter int PC_W       = 12,
  parameter int START_CYC  = 5,
  parameter int END_CYC    = 3,
  parameter int VEC_BASE   = 0,
  parameter int VEC_STRIDE = 16,
  localparam int AW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               stall,
  input  logic [PC_W-1:0]    if_pcnew,
  input  logic [PC_W-1:0]    if_PC,
  input  logic [6:0]         exe_opcode,
  input  logic [NUM_SRC-1:0] int_sig,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               if_prediction,
  input  logic               id_jump_in_bht,
  input  logic               id_sel_pc,
  input  logic [1:0]         exe_correction,
  output logic               ISR_PC_flush,
  output logic               ISR_pipe_flush,
  output logic               sel_ISR,
  output logic               ret_ISR,
  output logic               ISR_running,
  output logic [PC_W-1:0]    save_PC,
  output logic [PC_W-1:0]    isr_vector,
  output logic [AW-1:0]      active_id,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask
);

  localparam logic [6:0] OPC_URET = 7'b1110011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_END
  } state_t;

  state_t state, state_n;

  logic [2:0]         cnt, cnt_n;
  logic [NUM_SRC-1:0] hist;
  logic [NUM_SRC-1:0] cand;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] pending_n;
  logic [AW-1:0]      win;
  logic [PC_W-1:0]    vec_n;
  logic               hit;
  logic               accept;
  logic               uret;
  logic               seq;
  logic               pc_match;
  logic               cnt_ge2;
  logic               brch;
  logic               sel_n;
  logic               ret_n;
  logic               run_n;

  assign cand = pending & mask;
  assign uret = (exe_opcode == OPC_URET);
  assign brch = (|exe_correction) | if_prediction
              | (id_sel_pc & ~id_jump_in_bht);

`ifdef INTC_VECTORED_EN
  assign vec_n = PC_W'(VEC_BASE + int'(win) * VEC_STRIDE);
`else
  assign vec_n = PC_W'(VEC_BASE);
`endif

  // Lowest-index enabled pending source wins.
  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        hit = 1'b1;
        win = AW'(i);
      end
    end
  end

  // Pending update: new rising edges beat the acceptance clear.
  always_comb begin
    clr = '0;
    if (accept) clr[win] = 1'b1;
    pending_n = (pending & ~clr) | (int_sig & ~hist);
  end

  // Sequencer next state; stall freezes every transition.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sel_n   = sel_ISR;
    ret_n   = ret_ISR;
    run_n   = ISR_running;
    accept  = 1'b0;
    if (!stall) begin
      unique case (state)
        S_IDLE: begin
          if (hit) begin
            accept  = 1'b1;
            state_n = S_START;
            cnt_n   = 3'd1;
          end
        end
        S_START: begin
          if (cnt == 3'(START_CYC)) begin
            state_n = S_RUN;
            cnt_n   = 3'd0;
            sel_n   = 1'b1;
            run_n   = 1'b1;
          end else begin
            cnt_n = cnt + 3'd1;
          end
        end
        S_RUN: begin
          if (uret) begin
            state_n = S_END;
            cnt_n   = 3'd1;
            ret_n   = 1'b1;
            sel_n   = 1'b0;
          end
        end
        S_END: begin
          if (cnt == 3'(END_CYC)) begin
            state_n = S_IDLE;
            cnt_n   = 3'd0;
            ret_n   = 1'b0;
            run_n   = 1'b0;
          end else begin
            cnt_n = cnt + 3'd1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Flushes only during entry/exit sequences or a URET seen by the ISR.
  always_comb begin
    seq = (state == S_START) || (state == S_END)
       || ((state == S_RUN) && uret);
    pc_match = (save_PC == if_PC);
    cnt_ge2  = (cnt >= 3'd2);
    ISR_PC_flush = !stall && seq && !ret_ISR
                && (cnt_ge2 || pc_match);
    ISR_pipe_flush = !stall && seq
                  && ((cnt_ge2 && !ret_ISR) || ret_ISR || pc_match);
  end

  // Sequencer state and status registers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state       <= S_IDLE;
      cnt         <= 3'd0;
      sel_ISR     <= 1'b0;
      ret_ISR     <= 1'b0;
      ISR_running <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      sel_ISR     <= sel_n;
      ret_ISR     <= ret_n;
      ISR_running <= run_n;
    end
  end

  // Edge history, pending and mask keep running through stalls.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      hist    <= '0;
      pending <= '0;
      mask    <= '1;
    end else begin
      hist    <= int_sig;
      pending <= pending_n;
      if (mask_we) mask <= mask_wdata;
    end
  end

  // Latch the serviced source, its entry vector and the return PC.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      active_id  <= '0;
      isr_vector <= '0;
      save_PC    <= '0;
    end else begin
      if (accept) begin
        active_id  <= win;
        isr_vector <= vec_n;
      end
      if (state == S_START && (cnt == 3'd1 || brch))
        save_PC <= if_pcnew;
    end
  end

endmodule

// File: tb/tb_vectored_interrupt_controller.sv
// Directed bench for vectored_interrupt_controller (NUM_SRC=4, defaults).
// Expected values are hand-derived from the cycle-level behaviour of the block.
module tb_vectored_interrupt_controller;

  localparam logic [6:0] URET = 7'b1110011;

  logic        clk = 1'b0;
  logic        nrst;
  logic        stall;
  logic [11:0] if_pcnew;
  logic [11:0] if_PC;
  logic [6:0]  exe_opcode;
  logic [3:0]  int_sig;
  logic        mask_we;
  logic [3:0]  mask_wdata;
  logic        if_prediction;
  logic        id_jump_in_bht;
  logic        id_sel_pc;
  logic [1:0]  exe_correction;
  logic        ISR_PC_flush;
  logic        ISR_pipe_flush;
  logic        sel_ISR;
  logic        ret_ISR;
  logic        ISR_running;
  logic [11:0] save_PC;
  logic [11:0] isr_vector;
  logic [1:0]  active_id;
  logic [3:0]  pending;
  logic [3:0]  mask;

  int errs   = 0;
  int checks = 0;

  vectored_interrupt_controller dut (
    .clk           (clk),
    .nrst          (nrst),
    .stall         (stall),
    .if_pcnew      (if_pcnew),
    .if_PC         (if_PC),
    .exe_opcode    (exe_opcode),
    .int_sig       (int_sig),
    .mask_we       (mask_we),
    .mask_wdata    (mask_wdata),
    .if_prediction (if_prediction),
    .id_jump_in_bht(id_jump_in_bht),
    .id_sel_pc     (id_sel_pc),
    .exe_correction(exe_correction),
    .ISR_PC_flush  (ISR_PC_flush),
    .ISR_pipe_flush(ISR_pipe_flush),
    .sel_ISR       (sel_ISR),
    .ret_ISR       (ret_ISR),
    .ISR_running   (ISR_running),
    .save_PC       (save_PC),
    .isr_vector    (isr_vector),
    .active_id     (active_id),
    .pending       (pending),
    .mask          (mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] vexp(input int id);
`ifdef INTC_VECTORED_EN
    vexp = 32'(id * 16);
`else
    vexp = 32'(id * 0);
`endif
  endfunction

  // From START cnt=1 with no stall, run to RUN, issue URET, drain END.
  task automatic finish_isr();
    repeat (5) tick();
    exe_opcode = URET;
    tick();
    exe_opcode = 7'd0;
    repeat (3) tick();
  endtask

  initial begin
    nrst = 1'b0;
    stall = 1'b0;
    if_pcnew = 12'h041;
    if_PC = 12'h040;
    exe_opcode = 7'd0;
    int_sig = 4'd0;
    mask_we = 1'b0;
    mask_wdata = 4'd0;
    if_prediction = 1'b0;
    id_jump_in_bht = 1'b0;
    id_sel_pc = 1'b0;
    exe_correction = 2'd0;
    repeat (2) tick();
    chk("rst_mask", mask, 4'hf);
    chk("rst_pend", pending, 4'h0);
    chk("rst_sel", sel_ISR, 1'b0);
    chk("rst_run", ISR_running, 1'b0);
    chk("rst_save", save_PC, 12'h000);
    chk("rst_pcfl", ISR_PC_flush, 1'b0);
    chk("rst_ppfl", ISR_pipe_flush, 1'b0);
    nrst = 1'b1;
    tick();

    // single source 2
    int_sig = 4'b0100;
    tick();
    chk("s_pend", pending, 4'b0100);
    int_sig = 4'b0000;
    tick();
    chk("s_id", active_id, 2);
    chk("s_vec", isr_vector, vexp(2));
    chk("s_pclr", pending, 4'b0000);
    chk("s_c1_pcfl", ISR_PC_flush, 1'b0);
    tick();
    chk("s_save", save_PC, 12'h041);
    chk("s_c2_pcfl", ISR_PC_flush, 1'b1);
    chk("s_c2_ppfl", ISR_pipe_flush, 1'b1);
    repeat (3) tick();
    chk("s_sel_early", sel_ISR, 1'b0);
    tick();
    chk("s_sel", sel_ISR, 1'b1);
    chk("s_run", ISR_running, 1'b1);
    chk("s_run_pcfl", ISR_PC_flush, 1'b0);
    tick();
    exe_opcode = URET;
    tick();
    exe_opcode = 7'd0;
    chk("s_ret1", ret_ISR, 1'b1);
    chk("s_sel_off", sel_ISR, 1'b0);
    chk("s_end_ppfl", ISR_pipe_flush, 1'b1);
    chk("s_end_pcfl", ISR_PC_flush, 1'b0);
    tick();
    chk("s_ret2", ret_ISR, 1'b1);
    tick();
    chk("s_ret3", ret_ISR, 1'b1);
    chk("s_run3", ISR_running, 1'b1);
    tick();
    chk("s_ret_off", ret_ISR, 1'b0);
    chk("s_run_off", ISR_running, 1'b0);

    // URET while idle is ignored
    exe_opcode = URET;
    tick();
    exe_opcode = 7'd0;
    chk("idle_uret", ret_ISR, 1'b0);

    // priority: 3 and 1 together
    int_sig = 4'b1010;
    tick();
    chk("p_pend", pending, 4'b1010);
    tick();
    chk("p_id1", active_id, 1);
    chk("p_pend2", pending, 4'b1000);
    finish_isr();
    chk("p_idle", ISR_running, 1'b0);
    chk("p_keep", pending, 4'b1000);
    tick();
    chk("p_id3", active_id, 3);
    chk("p_vec3", isr_vector, vexp(3));
    chk("p_pend3", pending, 4'b0000);
    finish_isr();

    // mask blocks source 0
    mask_we = 1'b1;
    mask_wdata = 4'b1110;
    tick();
    mask_we = 1'b0;
    chk("m_mask", mask, 4'b1110);
    int_sig = 4'b1011;
    repeat (3) tick();
    chk("m_pend", pending, 4'b0001);
    chk("m_nostart", active_id, 3);
    mask_we = 1'b1;
    mask_wdata = 4'b1111;
    tick();
    mask_we = 1'b0;
    tick();
    chk("m_id0", active_id, 0);
    chk("m_pclr", pending, 4'b0000);

    // branch correction inside START (cnt=3)
    repeat (2) tick();
    exe_correction = 2'b01;
    if_pcnew = 12'h080;
    tick();
    exe_correction = 2'b00;
    if_pcnew = 12'h041;
    chk("b_save", save_PC, 12'h080);
    repeat (2) tick();
    chk("b_sel", sel_ISR, 1'b1);
    if_pcnew = 12'h0aa;
    if_prediction = 1'b1;
    tick();
    if_prediction = 1'b0;
    chk("b_run_hold", save_PC, 12'h080);
    if_PC = 12'h080;
    exe_opcode = URET;
    #1;
    chk("b_uret_pcfl", ISR_PC_flush, 1'b1);
    chk("b_uret_ppfl", ISR_pipe_flush, 1'b1);
    tick();
    exe_opcode = 7'd0;
    if_PC = 12'h040;
    if_pcnew = 12'h041;
    repeat (3) tick();
    chk("b_idle", ISR_running, 1'b0);

    // stall at cnt=2 for 4 cycles
    int_sig = 4'b1111;
    repeat (2) tick();
    chk("t_id2", active_id, 2);
    tick();
    stall = 1'b1;
    #1;
    chk("t_pcfl", ISR_PC_flush, 1'b0);
    chk("t_ppfl", ISR_pipe_flush, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t_hold_sel", sel_ISR, 1'b0);
      chk("t_hold_fl", ISR_pipe_flush, 1'b0);
    end
    stall = 1'b0;
    #1;
    chk("t_resume_pcfl", ISR_PC_flush, 1'b1);
    repeat (3) tick();
    chk("t_sel_early", sel_ISR, 1'b0);
    tick();
    chk("t_sel", sel_ISR, 1'b1);

    // reset in RUN
    int_sig = 4'b0000;
    nrst = 1'b0;
    tick();
    chk("r_sel", sel_ISR, 1'b0);
    chk("r_run", ISR_running, 1'b0);
    chk("r_mask", mask, 4'hf);
    chk("r_id", active_id, 0);
    chk("r_vec", isr_vector, 12'h000);
    chk("r_save", save_PC, 12'h000);
    chk("r_ppfl", ISR_pipe_flush, 1'b0);
    nrst = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
